// File: rtl/multicycle_control.sv
// multicycle_control: MIPS multicycle control FSM with memory-ready stall, timeout fault and illegal-opcode flag
// Ports: clk, reset (async, active-high); OP, Funct, Zero, MemReady in;
// PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB,
// ALUOp, PCSource, IllegalOp, MemFault (sticky), State (debug) out.
// Optional macro JAL_JR_EN enables the JAL and JR instructions.
module multicycle_control #(
    parameter int ALUOP_WIDTH    = 3,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [5:0]             OP,
    input  logic [5:0]             Funct,
    input  logic                   Zero,
    input  logic                   MemReady,
    output logic                   PCWrite,
    output logic                   IorD,
    output logic                   MemRead,
    output logic                   MemWrite,
    output logic                   IRWrite,
    output logic [1:0]             RegDst,
    output logic [1:0]             MemtoReg,
    output logic                   RegWrite,
    output logic                   ALUSrcA,
    output logic [1:0]             ALUSrcB,
    output logic [ALUOP_WIDTH-1:0] ALUOp,
    output logic [1:0]             PCSource,
    output logic                   IllegalOp,
    output logic                   MemFault,
    output logic [3:0]             State
);
    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_RWB    = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_IEXEC  = 4'd9;
    localparam logic [3:0] S_IWB    = 4'd10;
    localparam logic [3:0] S_JUMP   = 4'd11;
    localparam logic [3:0] S_JAL    = 4'd12;
    localparam logic [3:0] S_JR     = 4'd13;
    localparam logic [3:0] S_HALT   = 4'd15;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] F_JR     = 6'h08;

    logic [3:0] state_q, state_d, next_s, dispatch;
    logic [7:0] cnt_q, cnt_d;
    logic [5:0] op_q, op_d;
    logic       fault_q, fault_d;
    logic       illegal, waiting, timeout;
    logic [2:0] aluop;

`ifndef JAL_JR_EN
    logic unused_funct;
    assign unused_funct = ^Funct;
`endif

    always_comb begin
        dispatch = S_FETCH;
        illegal  = 1'b0;
        case (OP)
`ifdef JAL_JR_EN
            OP_RTYPE:       dispatch = (Funct == F_JR) ? S_JR : S_EXEC;
            OP_JAL:         dispatch = S_JAL;
`else
            OP_RTYPE:       dispatch = S_EXEC;
`endif
            OP_LW, OP_SW:   dispatch = S_MEMADR;
            OP_BEQ, OP_BNE: dispatch = S_BRANCH;
            OP_ADDI, OP_ORI, OP_LUI: dispatch = S_IEXEC;
            OP_J:           dispatch = S_JUMP;
            default:        illegal  = 1'b1;
        endcase
    end

    always_comb begin
        case (state_q)
            S_FETCH:  next_s = MemReady ? S_DECODE : S_FETCH;
            S_DECODE: next_s = dispatch;
            S_MEMADR: next_s = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  next_s = MemReady ? S_MEMWB : S_MEMRD;
            S_MEMWR:  next_s = MemReady ? S_FETCH : S_MEMWR;
            S_EXEC:   next_s = S_RWB;
            S_IEXEC:  next_s = S_IWB;
            S_HALT:   next_s = S_HALT;
            default:  next_s = S_FETCH;
        endcase
        waiting = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
        // A stalled access stays in its state, so the counter only needs clearing when ready or on timeout.
        timeout = waiting && !MemReady && (cnt_q == 8'(TIMEOUT_CYCLES - 1));
        state_d = timeout ? S_HALT : next_s;
        cnt_d   = (waiting && !MemReady && !timeout) ? cnt_q + 8'd1 : 8'd0;
        fault_d = fault_q | timeout;
        // The opcode is latched in DECODE so later states do not depend on IR timing.
        op_d    = (state_q == S_DECODE) ? OP : op_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            cnt_q   <= 8'd0;
            fault_q <= 1'b0;
            op_q    <= 6'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
            op_q    <= op_d;
        end
    end

    // Everything is held at zero while reset is high, including FETCH's MemRead.
    always_comb begin
        PCWrite   = 1'b0;
        IorD      = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegDst    = 2'b00;
        MemtoReg  = 2'b00;
        RegWrite  = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        aluop     = 3'b000;
        PCSource  = 2'b00;
        IllegalOp = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    IRWrite = MemReady;
                    PCWrite = MemReady;
                end
                S_DECODE: begin
                    ALUSrcB   = 2'b11;
                    IllegalOp = illegal;
                end
                S_MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                S_MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_MEMWB: begin
                    MemtoReg = 2'b01;
                    RegWrite = 1'b1;
                end
                S_MEMWR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                S_EXEC: begin
                    ALUSrcA = 1'b1;
                    aluop   = 3'b111;
                end
                S_RWB: begin
                    RegDst   = 2'b01;
                    RegWrite = 1'b1;
                end
                S_IEXEC: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    aluop   = (op_q == OP_ADDI) ? 3'b100 : (op_q == OP_ORI) ? 3'b101 : 3'b110;
                end
                S_IWB: RegWrite = 1'b1;
                S_BRANCH: begin
                    ALUSrcA  = 1'b1;
                    aluop    = 3'b001;
                    PCSource = 2'b01;
                    PCWrite  = (op_q == OP_BNE) ? ~Zero : Zero;
                end
                S_JUMP: begin
                    PCSource = 2'b10;
                    PCWrite  = 1'b1;
                end
`ifdef JAL_JR_EN
                S_JAL: begin
                    PCSource = 2'b10;
                    PCWrite  = 1'b1;
                    RegDst   = 2'b10;
                    MemtoReg = 2'b10;
                    RegWrite = 1'b1;
                end
                S_JR: begin
                    PCSource = 2'b11;
                    PCWrite  = 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    assign ALUOp    = ALUOP_WIDTH'(aluop);
    assign MemFault = fault_q;
    assign State    = state_q;
endmodule
